// File: rtl/ktc32_loader_pkg.sv
// Shared types and frame constants for the UART boot loader.
package ktc32_loader_pkg;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid / frame_err.
module uart_rx
  import ktc32_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          st_d  = RX_START;
          cnt_d = HALF_TC;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // A glitch that is gone by mid start bit is not a start.
          if (!rx_sync_q) begin
            st_d  = RX_DATA;
            cnt_d = FULL_TC;
            bit_d = 3'd7;
          end else begin
            st_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          cnt_d   = FULL_TC;
          if (bit_q == 3'd0) st_d = RX_STOP;
          else               bit_d = bit_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          valid_d = rx_sync_q;
          ferr_d  = !rx_sync_q;
          st_d    = RX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      st_q      <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data      = shreg_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// UART program loader: length-prefixed little-endian image into RAM, CPU held in reset until done.
// Optional trailing XOR checksum byte when UART_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | line quiet, nothing received since reset
// LEN   | collecting the 4-byte word count
// DATA  | collecting words, one RAM write per 4 bytes
// CHECK | waiting for the checksum byte (checksum build only)
// DONE  | image loaded, CPU released, rx ignored
// ERROR | framing/length/checksum fault, CPU held, rx ignored
module uart_loader
  import ktc32_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;
  localparam logic [1:0]  LAST_LEN_BYTE  = 2'(LEN_BYTES - 1);
  localparam logic [1:0]  LAST_WORD_BYTE = 2'(WORD_BYTES - 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  loader_state_t         state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           shift_q, shift_d;
  logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_reset_q;
  logic [31:0]           shift_word;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign shift_word = {rx_data, shift_q[31:8]};

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    words_left_d = words_left_q;
    word_idx_d   = word_idx_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_ferr) begin
          state_d = ERROR;
        end else if (rx_valid) begin
          shift_d    = shift_word;
          byte_idx_d = 2'd1;
          state_d    = LEN;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      LEN: begin
        if (rx_ferr) begin
          state_d = ERROR;
        end else if (rx_valid) begin
          shift_d    = shift_word;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == LAST_LEN_BYTE) begin
            byte_idx_d = 2'd0;
            if (shift_word == 32'd0) begin
              state_d = DONE;
            end else if ({1'b0, shift_word} > CAPACITY) begin
              state_d = ERROR;
            end else begin
              words_left_d = shift_word[ADDR_WIDTH:0];
              state_d      = DATA;
            end
          end
        end
      end
      DATA: begin
        if (rx_ferr) begin
          state_d = ERROR;
        end else if (rx_valid) begin
          shift_d    = shift_word;
          byte_idx_d = byte_idx_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_idx_q == LAST_WORD_BYTE) begin
            we_d         = 1'b1;
            addr_d       = word_idx_q;
            wdata_d      = shift_word;
            word_idx_d   = word_idx_q + 1'b1;
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == (ADDR_WIDTH + 1)'(1)) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
`endif
            end
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_ferr) begin
          state_d = ERROR;
        end else if (rx_valid) begin
          state_d = (rx_data == csum_q) ? DONE : ERROR;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_reset_q  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      words_left_q <= words_left_d;
      word_idx_q   <= word_idx_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      // Lags DONE entry by a cycle so release never coincides with the last write.
      cpu_reset_q  <= (state_q == DONE);
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);
  assign error     = (state_q == ERROR);

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader; checksum-specific frames follow UART_LOADER_CHECKSUM_EN.
module tb_uart_loader;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int AW       = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          cpu_reset, busy, error;

  uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  int          we_cnt = 0;
  int          last_we_cyc = 0;
  int          rise_cyc = 0;
  logic        cpu_prev = 1'b0;
  logic [31:0] wa [32];
  logic [31:0] wd [32];

  always @(negedge clk) begin
    if (ram_we) begin
      if (we_cnt < 32) begin
        wa[we_cnt] = 32'(ram_addr);
        wd[we_cnt] = ram_wdata;
      end
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (cpu_reset && !cpu_prev) rise_cyc = cyc;
    cpu_prev = cpu_reset;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic settle();
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".we"},    32'(ram_we),    32'd0);
    check({tag, ".addr"},  32'(ram_addr),  32'd0);
    check({tag, ".wdata"}, ram_wdata,      32'd0);
    check({tag, ".cpu"},   32'(cpu_reset), 32'd0);
    check({tag, ".busy"},  32'(busy),      32'd0);
    check({tag, ".err"},   32'(error),     32'd0);
  endtask

  int base;

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // N=2 image
    base = we_cnt;
    send_byte(8'h02, 1'b1);
    check("n2.busy_mid", 32'(busy), 32'd1);
    check("n2.cpu_mid",  32'(cpu_reset), 32'd0);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h31, 1'b1);
`endif
    settle();
    check("n2.count", 32'(we_cnt - base), 32'd2);
    check("n2.addr0", wa[base],     32'd0);
    check("n2.data0", wd[base],     32'h0000_0013);
    check("n2.addr1", wa[base + 1], 32'd1);
    check("n2.data1", wd[base + 1], 32'hDEAD_BEEF);
    check("n2.cpu",   32'(cpu_reset), 32'd1);
    check("n2.err",   32'(error), 32'd0);
    check("n2.busy",  32'(busy), 32'd0);
`ifdef UART_LOADER_CHECKSUM_EN
    check("n2.rise_after_we", 32'(rise_cyc > last_we_cyc + 1), 32'd1);
`else
    check("n2.rise_lag", 32'(rise_cyc - last_we_cyc), 32'd1);
`endif

    // N=0 image
    pulse_reset();
    base = we_cnt;
    send_word(32'h0000_0000);
    settle();
    check("n0.count", 32'(we_cnt - base), 32'd0);
    check("n0.cpu",   32'(cpu_reset), 32'd1);
    check("n0.err",   32'(error), 32'd0);
    check("n0.busy",  32'(busy), 32'd0);

    // Oversized length
    pulse_reset();
    base = we_cnt;
    send_word(32'h0000_4001);
    settle();
    check("big.err",   32'(error), 32'd1);
    check("big.cpu",   32'(cpu_reset), 32'd0);
    check("big.count", 32'(we_cnt - base), 32'd0);
    check("big.busy",  32'(busy), 32'd0);

    // Framing error on third data byte, valid traffic after
    pulse_reset();
    base = we_cnt;
    send_word(32'h0000_0002);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    repeat (CPB) @(negedge clk);
    send_byte(8'h44, 1'b1);
    send_word(32'h5566_7788);
    settle();
    check("ferr.err",   32'(error), 32'd1);
    check("ferr.count", 32'(we_cnt - base), 32'd0);
    check("ferr.cpu",   32'(cpu_reset), 32'd0);
    check("ferr.busy",  32'(busy), 32'd0);

    // Reset mid-load, then a fresh frame
    pulse_reset();
    base = we_cnt;
    send_word(32'h0000_0003);
    send_word(32'h1234_5678);
    settle();
    check("mid.count", 32'(we_cnt - base), 32'd1);
    check("mid.data0", wd[base], 32'h1234_5678);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    base = we_cnt;
    send_word(32'h0000_0001);
    send_word(32'hA5A5_0001);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h01, 1'b1);
`endif
    settle();
    check("fresh.count", 32'(we_cnt - base), 32'd1);
    check("fresh.addr",  wa[base], 32'd0);
    check("fresh.data",  wd[base], 32'hA5A5_0001);
    check("fresh.cpu",   32'(cpu_reset), 32'd1);

`ifdef UART_LOADER_CHECKSUM_EN
    pulse_reset();
    base = we_cnt;
    send_word(32'h0000_0001);
    send_word(32'h1122_3344);
    send_byte(8'h44, 1'b1);
    settle();
    check("cs_ok.cpu", 32'(cpu_reset), 32'd1);
    check("cs_ok.err", 32'(error), 32'd0);

    pulse_reset();
    base = we_cnt;
    send_word(32'h0000_0001);
    send_word(32'h1122_3344);
    send_byte(8'h45, 1'b1);
    settle();
    check("cs_bad.err",   32'(error), 32'd1);
    check("cs_bad.cpu",   32'(cpu_reset), 32'd0);
    check("cs_bad.count", 32'(we_cnt - base), 32'd1);
    check("cs_bad.addr",  wa[base], 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
